// File: rtl/mem_bus_arbiter.sv
// Arbitrates one downstream memory port between icache refills and dcache accesses; grant-to-ack 1 cycle.
// One transaction at a time; m_req holds until m_addr_ok, beats may arrive with gaps, requests wait in IDLE.
module mem_bus_arbiter #(
  parameter int LINE_WORDS   = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ic_req,
  input  logic [31:0] ic_addr,
  output logic        ic_ack,
  output logic        ic_rvalid,
  output logic [31:0] ic_rdata,
  output logic        ic_done,
  input  logic        dc_req,
  input  logic        dc_wr,
  input  logic [31:0] dc_addr,
  input  logic [31:0] dc_wdata,
  input  logic [3:0]  dc_wstrb,
  output logic        dc_ack,
  output logic        dc_rvalid,
  output logic [31:0] dc_rdata,
  output logic        dc_done,
  output logic        m_req,
  output logic        m_wr,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic [3:0]  m_len,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  input  logic [31:0] m_rdata
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  localparam logic [3:0] IC_LEN     = 4'(LINE_WORDS - 1);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_t      state_q;
  logic        owner_ic_q;
  logic [3:0]  beat_q, starve_q;
  logic        m_req_q, m_wr_q;
  logic [31:0] m_addr_q, m_wdata_q;
  logic [3:0]  m_wstrb_q, m_len_q;
  logic        ic_ack_q, ic_rvalid_q, ic_done_q;
  logic        dc_ack_q, dc_rvalid_q, dc_done_q;
  logic [31:0] ic_rdata_q, dc_rdata_q;

  logic        ic_win_d, dc_win_d, last_beat_d;
  logic [3:0]  starve_d;

  // Dcache normally wins; a saturated starvation count hands the port to a waiting icache.
  always_comb begin
    ic_win_d    = ic_req && (!dc_req || (starve_q == STARVE_MAX));
    dc_win_d    = dc_req && !ic_win_d;
    last_beat_d = (beat_q == m_len_q);
    starve_d    = starve_q;
    if (ic_win_d || (dc_win_d && !ic_req))
      starve_d = 4'd0;
    else if (dc_win_d)
      starve_d = (starve_q == STARVE_MAX) ? STARVE_MAX : starve_q + 4'd1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      owner_ic_q  <= 1'b0;
      beat_q      <= 4'd0;
      starve_q    <= 4'd0;
      m_req_q     <= 1'b0;
      m_wr_q      <= 1'b0;
      m_addr_q    <= 32'd0;
      m_wdata_q   <= 32'd0;
      m_wstrb_q   <= 4'd0;
      m_len_q     <= 4'd0;
      ic_ack_q    <= 1'b0;
      ic_rvalid_q <= 1'b0;
      ic_done_q   <= 1'b0;
      ic_rdata_q  <= 32'd0;
      dc_ack_q    <= 1'b0;
      dc_rvalid_q <= 1'b0;
      dc_done_q   <= 1'b0;
      dc_rdata_q  <= 32'd0;
    end else begin
      ic_ack_q    <= 1'b0;
      dc_ack_q    <= 1'b0;
      ic_rvalid_q <= 1'b0;
      dc_rvalid_q <= 1'b0;
      ic_done_q   <= 1'b0;
      dc_done_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ic_win_d || dc_win_d) begin
            starve_q   <= starve_d;
            owner_ic_q <= ic_win_d;
            beat_q     <= 4'd0;
            m_req_q    <= 1'b1;
            state_q    <= ADDR;
            if (ic_win_d) begin
              m_addr_q  <= ic_addr;
              m_wr_q    <= 1'b0;
              m_wdata_q <= 32'd0;
              m_wstrb_q <= 4'd0;
              m_len_q   <= IC_LEN;
              ic_ack_q  <= 1'b1;
            end else begin
              m_addr_q  <= dc_addr;
              m_wr_q    <= dc_wr;
              m_wdata_q <= dc_wdata;
              m_wstrb_q <= dc_wstrb;
              m_len_q   <= 4'd0;
              dc_ack_q  <= 1'b1;
            end
          end
        end
        ADDR: begin
          // Early m_data_ok is a protocol violation and is dropped here.
          if (m_addr_ok) begin
            m_req_q <= 1'b0;
            state_q <= DATA;
          end
        end
        DATA: begin
          if (m_data_ok) begin
            beat_q <= beat_q + 4'd1;
            if (!m_wr_q) begin
              if (owner_ic_q) begin
                ic_rvalid_q <= 1'b1;
                ic_rdata_q  <= m_rdata;
              end else begin
                dc_rvalid_q <= 1'b1;
                dc_rdata_q  <= m_rdata;
              end
            end
            if (last_beat_d) begin
              ic_done_q <= owner_ic_q;
              dc_done_q <= !owner_ic_q;
              state_q   <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ic_ack    = ic_ack_q;
  assign ic_rvalid = ic_rvalid_q;
  assign ic_rdata  = ic_rdata_q;
  assign ic_done   = ic_done_q;
  assign dc_ack    = dc_ack_q;
  assign dc_rvalid = dc_rvalid_q;
  assign dc_rdata  = dc_rdata_q;
  assign dc_done   = dc_done_q;
  assign m_req     = m_req_q;
  assign m_wr      = m_wr_q;
  assign m_addr    = m_addr_q;
  assign m_wdata   = m_wdata_q;
  assign m_wstrb   = m_wstrb_q;
  assign m_len     = m_len_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: scenario tasks with a read-beat scoreboard queue.
module tb_mem_bus_arbiter;
  localparam int LW = 8;
  localparam int SL = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ic_req, ic_ack, ic_rvalid, ic_done;
  logic [31:0] ic_addr, ic_rdata;
  logic        dc_req, dc_wr, dc_ack, dc_rvalid, dc_done;
  logic [31:0] dc_addr, dc_wdata, dc_rdata;
  logic [3:0]  dc_wstrb;
  logic        m_req, m_wr, m_addr_ok, m_data_ok;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_wstrb, m_len;

  typedef struct packed {
    logic        ic;
    logic [31:0] data;
    logic        last;
  } beat_t;
  beat_t sb_q[$];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.LINE_WORDS(LW), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .resetn(resetn),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_ack(ic_ack), .ic_rvalid(ic_rvalid),
    .ic_rdata(ic_rdata), .ic_done(ic_done),
    .dc_req(dc_req), .dc_wr(dc_wr), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_wstrb(dc_wstrb), .dc_ack(dc_ack), .dc_rvalid(dc_rvalid), .dc_rdata(dc_rdata),
    .dc_done(dc_done),
    .m_req(m_req), .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_len(m_len), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata)
  );

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Answers an accepted transaction: address accept, then nbeats back-to-back beats; ends in the done cycle.
  task automatic serve(input int nbeats);
    m_addr_ok = 1'b1;
    tick();
    m_addr_ok = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      m_data_ok = 1'b1;
      m_rdata   = $urandom;
      tick();
    end
    m_data_ok = 1'b0;
  endtask

  task automatic test_reset;
    logic [179:0] outs;
    resetn = 1'b0;
    ic_req = 0; ic_addr = 0; dc_req = 0; dc_wr = 0; dc_addr = 0; dc_wdata = 0; dc_wstrb = 0;
    m_addr_ok = 0; m_data_ok = 0; m_rdata = 0;
    tick(); tick();
    outs = {ic_ack, ic_rvalid, ic_rdata, ic_done, dc_ack, dc_rvalid, dc_rdata, dc_done,
            m_req, m_wr, m_addr, m_wdata, m_wstrb, m_len};
    checks++;
    if (outs !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got %h required 0", outs);
    end
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_dc_read;
    beat_t b;
    dc_req = 1; dc_wr = 0; dc_addr = 32'h1000; dc_wstrb = 4'hF;
    tick();
    checks++;
    if ({dc_ack, ic_ack, m_req, m_wr, m_len, m_addr} !== {3'b101, 1'b0, 4'd0, 32'h1000}) begin
      failures++;
      $display("FAIL dc_read_grant: got ack/ic_ack/req/wr/len/addr=%b%b%b%b %h %h required 1010 0 00001000",
               dc_ack, ic_ack, m_req, m_wr, m_len, m_addr);
    end
    dc_req = 0; m_addr_ok = 1;
    tick();
    checks++;
    if ({dc_ack, m_req, dc_done} !== 3'b000) begin
      failures++;
      $display("FAIL dc_read_data_phase: got ack/req/done=%b%b%b required 000", dc_ack, m_req, dc_done);
    end
    m_addr_ok = 0; m_data_ok = 1; m_rdata = 32'hDEADBEEF;
    sb_q.push_back('{ic: 1'b0, data: 32'hDEADBEEF, last: 1'b1});
    tick();
    m_data_ok = 0;
    checks++;
    if (dc_rvalid !== 1'b1 || sb_q.size() == 0) begin
      failures++;
      $display("FAIL dc_read_rvalid: got rvalid=%b required 1", dc_rvalid);
    end else begin
      b = sb_q.pop_front();
      checks++;
      if ({dc_rdata, dc_done, ic_rvalid} !== {b.data, b.last, b.ic}) begin
        failures++;
        $display("FAIL dc_read_beat: got rdata=%h done=%b required rdata=%h done=%b",
                 dc_rdata, dc_done, b.data, b.last);
      end
    end
    tick();
  endtask

  task automatic test_ic_burst;
    beat_t b;
    logic  sched [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    int    beat = 0;
    int    pulses = 0;
    ic_req = 1; ic_addr = 32'h2000;
    tick();
    checks++;
    if ({ic_ack, dc_ack, m_req, m_wr, m_len, m_addr} !== {4'b1010, 4'(LW - 1), 32'h2000}) begin
      failures++;
      $display("FAIL ic_burst_grant: got ack/dc_ack/req/wr=%b%b%b%b len=%h addr=%h required 1010 len=%h addr=00002000",
               ic_ack, dc_ack, m_req, m_wr, m_len, m_addr, 4'(LW - 1));
    end
    ic_req = 0; m_addr_ok = 1;
    tick();
    m_addr_ok = 0;
    for (int i = 0; i < 9; i++) begin
      m_data_ok = sched[i];
      if (sched[i]) begin
        m_rdata = 32'h2000_0000 + 32'(beat);
        sb_q.push_back('{ic: 1'b1, data: m_rdata, last: (beat == LW - 1)});
        beat++;
      end
      tick();
      checks++;
      if (ic_rvalid !== sched[i]) begin
        failures++;
        $display("FAIL ic_burst_rvalid[%0d]: got %b required %b", i, ic_rvalid, sched[i]);
      end
      if (ic_rvalid === 1'b1 && sb_q.size() != 0) begin
        b = sb_q.pop_front();
        pulses++;
        checks++;
        if ({ic_rdata, ic_done} !== {b.data, b.last}) begin
          failures++;
          $display("FAIL ic_burst_beat[%0d]: got rdata=%h done=%b required rdata=%h done=%b",
                   i, ic_rdata, ic_done, b.data, b.last);
        end
      end else begin
        checks++;
        if (ic_done !== 1'b0) begin
          failures++;
          $display("FAIL ic_burst_gap_done[%0d]: got %b required 0", i, ic_done);
        end
      end
    end
    m_data_ok = 0;
    checks++;
    if (pulses != LW) begin
      failures++;
      $display("FAIL ic_burst_pulse_count: got %0d required %0d", pulses, LW);
    end
    tick();
  endtask

  task automatic test_simultaneous;
    beat_t b;
    ic_req = 1; ic_addr = 32'h7000;
    dc_req = 1; dc_wr = 0; dc_addr = 32'h3000;
    tick();
    checks++;
    if ({dc_ack, ic_ack, m_addr} !== {2'b10, 32'h3000}) begin
      failures++;
      $display("FAIL simul_first_grant: got dc_ack=%b ic_ack=%b addr=%h required 1 0 00003000",
               dc_ack, ic_ack, m_addr);
    end
    dc_req = 0; m_addr_ok = 1;
    tick();
    m_addr_ok = 0; m_data_ok = 1; m_rdata = 32'h13572468;
    sb_q.push_back('{ic: 1'b0, data: 32'h13572468, last: 1'b1});
    tick();
    m_data_ok = 0;
    checks++;
    if (dc_rvalid !== 1'b1 || sb_q.size() == 0) begin
      failures++;
      $display("FAIL simul_dc_rvalid: got %b required 1", dc_rvalid);
    end else begin
      b = sb_q.pop_front();
      checks++;
      if ({dc_rdata, dc_done, ic_ack} !== {b.data, b.last, 1'b0}) begin
        failures++;
        $display("FAIL simul_dc_beat: got rdata=%h done=%b ic_ack=%b required rdata=%h done=%b ic_ack=0",
                 dc_rdata, dc_done, ic_ack, b.data, b.last);
      end
    end
    tick();
    checks++;
    if ({ic_ack, dc_ack, m_addr, m_len} !== {2'b10, 32'h7000, 4'(LW - 1)}) begin
      failures++;
      $display("FAIL simul_second_grant: got ic_ack=%b dc_ack=%b addr=%h len=%h required 1 0 00007000 %h",
               ic_ack, dc_ack, m_addr, m_len, 4'(LW - 1));
    end
    ic_req = 0;
    serve(LW);
    checks++;
    if (ic_done !== 1'b1) begin
      failures++;
      $display("FAIL simul_ic_done: got %b required 1", ic_done);
    end
    tick();
  endtask

  task automatic test_starvation;
    logic exp_ic;
    ic_req = 1; ic_addr = 32'h5000;
    dc_req = 1; dc_wr = 0; dc_addr = 32'h6000;
    for (int g = 1; g <= SL + 2; g++) begin
      exp_ic = (g == SL + 1);
      tick();
      checks++;
      if ({ic_ack, dc_ack} !== {exp_ic, !exp_ic}) begin
        failures++;
        $display("FAIL starve_grant[%0d]: got ic_ack=%b dc_ack=%b required %b %b",
                 g, ic_ack, dc_ack, exp_ic, !exp_ic);
      end
      if (exp_ic) begin
        ic_req = 0;
        serve(LW);
        checks++;
        if (ic_done !== 1'b1) begin
          failures++;
          $display("FAIL starve_ic_done[%0d]: got %b required 1", g, ic_done);
        end
        ic_req = 1;
      end else begin
        dc_req = 0;
        serve(1);
        checks++;
        if (dc_done !== 1'b1) begin
          failures++;
          $display("FAIL starve_dc_done[%0d]: got %b required 1", g, dc_done);
        end
      end
      dc_req = 1;
    end
    dc_req = 0; ic_req = 0;
    tick();
  endtask

  task automatic test_dc_write;
    dc_req = 1; dc_wr = 1; dc_addr = 32'h4000; dc_wdata = 32'hCAFEF00D; dc_wstrb = 4'b0011;
    tick();
    checks++;
    if (dc_ack !== 1'b1) begin
      failures++;
      $display("FAIL dc_write_ack: got %b required 1", dc_ack);
    end
    dc_req = 0; dc_wr = 0; dc_addr = 32'hFFFF_FFFF; dc_wdata = 0; dc_wstrb = 0;
    for (int c = 1; c <= 6; c++) begin
      checks++;
      if ({m_req, m_wr, m_addr, m_wdata, m_wstrb, m_len} !==
          {2'b11, 32'h4000, 32'hCAFEF00D, 4'b0011, 4'd0}) begin
        failures++;
        $display("FAIL dc_write_hold[%0d]: got req=%b wr=%b addr=%h wdata=%h wstrb=%b len=%h required 1 1 00004000 cafef00d 0011 0",
                 c, m_req, m_wr, m_addr, m_wdata, m_wstrb, m_len);
      end
      if (c == 6) m_addr_ok = 1;
      tick();
    end
    m_addr_ok = 0;
    checks++;
    if (m_req !== 1'b0) begin
      failures++;
      $display("FAIL dc_write_req_drop: got %b required 0", m_req);
    end
    m_data_ok = 1;
    tick();
    m_data_ok = 0;
    checks++;
    if ({dc_done, dc_rvalid} !== 2'b10) begin
      failures++;
      $display("FAIL dc_write_done: got done=%b rvalid=%b required 1 0", dc_done, dc_rvalid);
    end
    tick();
  endtask

  task automatic test_reset_mid_burst;
    logic [179:0] outs;
    ic_req = 1; ic_addr = 32'h8000;
    tick();
    ic_req = 0; m_addr_ok = 1;
    tick();
    m_addr_ok = 0;
    for (int i = 0; i < 3; i++) begin
      m_data_ok = 1; m_rdata = 32'hA0A0_0000 + 32'(i);
      tick();
    end
    checks++;
    if (ic_rvalid !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_beat3: got rvalid=%b required 1", ic_rvalid);
    end
    m_rdata = 32'hA0A0_0003;
    #1 resetn = 1'b0;
    #1;
    outs = {ic_ack, ic_rvalid, ic_rdata, ic_done, dc_ack, dc_rvalid, dc_rdata, dc_done,
            m_req, m_wr, m_addr, m_wdata, m_wstrb, m_len};
    checks++;
    if (outs !== '0) begin
      failures++;
      $display("FAIL reset_mid_outputs: got %h required 0", outs);
    end
    m_data_ok = 0;
    tick(); tick();
    resetn = 1'b1;
    tick();
    dc_req = 1; dc_wr = 0; dc_addr = 32'h9000;
    tick();
    checks++;
    if ({dc_ack, ic_ack, m_addr} !== {2'b10, 32'h9000}) begin
      failures++;
      $display("FAIL reset_mid_regrant: got dc_ack=%b ic_ack=%b addr=%h required 1 0 00009000",
               dc_ack, ic_ack, m_addr);
    end
    dc_req = 0;
    serve(1);
    checks++;
    if (dc_done !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_regrant_done: got %b required 1", dc_done);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_dc_read();
    test_ic_burst();
    test_simultaneous();
    test_starvation();
    test_dc_write();
    test_reset_mid_burst();
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending beats required 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares the single downstream memory port between the instruction-cache refill engine and the data-cache miss/uncached engine. A small FSM accepts one requester at a time, issues one address phase, and returns read beats or a write completion to that requester. Its per-requester `done` pulses are what clear `icache_stall` and `mem_stall` in the pipeline stall logic. Dcache has priority because a dcache miss freezes the whole pipeline. A starvation guard bounds how long instruction fetch can be locked out.

## Interface
- `LINE_WORDS`, 8, beats per icache refill burst (1..16).
- `STARVE_LIMIT`, 4, consecutive dcache grants after which a pending icache request wins (1..15).
- `clk` in 1: single clock, rising edge.
- `resetn` in 1: reset, asynchronous assert, active-low.
- `ic_req` in 1: icache refill request, level.
- `ic_addr` in 32: line-aligned refill address.
- `ic_ack` out 1: one-cycle grant pulse.
- `ic_rvalid` out 1: one refill beat valid.
- `ic_rdata` out 32: refill beat data.
- `ic_done` out 1: one-cycle pulse on the last beat.
- `dc_req` in 1: dcache request, level.
- `dc_wr` in 1: 1 = write, 0 = read.
- `dc_addr` in 32: word address.
- `dc_wdata` in 32: write data.
- `dc_wstrb` in 4: byte enables; ignored on reads.
- `dc_ack`, `dc_rvalid`, `dc_rdata`, `dc_done`: as the `ic_*` outputs. A dcache transaction is always one beat.
- `m_req` out 1: address phase valid.
- `m_wr` out 1: write.
- `m_addr` out 32: transaction address.
- `m_wdata` out 32: write data.
- `m_wstrb` out 4: byte enables.
- `m_len` out 4: beats minus 1.
- `m_addr_ok` in 1: address phase accepted.
- `m_data_ok` in 1: one read beat, or the write response.
- `m_rdata` in 32: read beat data.

## Operation
- States: IDLE, ADDR, DATA. Reset state is IDLE.
- **IDLE**
  - Samples `dc_req` and `ic_req`. Dcache wins, except when `ic_req` is high and `starve_cnt == STARVE_LIMIT`; then icache wins.
  - On a grant, latches the winner's addr, wr, wdata and wstrb into output registers.
    - Icache grant: `m_wr=0`, `m_len=LINE_WORDS-1`.
    - Dcache grant: `m_len=0`.
  - Pulses the winner's `ack`, clears the beat counter and goes to ADDR.
- **ADDR**
  - `m_req=1`, held with stable `m_*` fields until `m_addr_ok`, then go to DATA.
  - `m_data_ok` in ADDR is a protocol violation and is ignored.
- **DATA**
  - Each `m_data_ok` increments the beat counter.
  - For reads, registers `m_rdata` into the owner's `rdata` and sets its `rvalid` for one cycle.
  - On the beat where `count == m_len`, also pulses the owner's `done` and goes to IDLE.
  - For writes, `done` pulses and `rvalid` stays 0.
- **starve_cnt** (4 bits)
  - Increments on a dcache grant while `ic_req` is high, saturating at `STARVE_LIMIT`.
  - Clears on any icache grant, and on any grant while `ic_req` is low.
- **Requester rule**: hold `req` and its fields stable until `ack`. Do not re-raise `req` before your own `done`. The arbiter never re-samples during ADDR/DATA, so no duplicate grant is possible.
- **Reset mid-transaction**: state, counters and all outputs clear immediately. The in-flight downstream transaction is abandoned; the memory side is reset from the same `resetn`.

## Timing
- Reset values: every output is 0. This includes `m_req`, `m_len`, `m_addr`, and all `ack`/`rvalid`/`done`/`rdata`.
- `req` seen high at edge t → `ack` and `m_req` high during cycle t+1.
- `m_addr_ok` at edge t+1 → DATA from t+2. `m_addr_ok` may be delayed indefinitely.
- `m_data_ok` at edge u → `rvalid`/`rdata` (and `done` on the last beat) high during cycle u+1, with state already IDLE in that cycle.
- Minimum dcache read: `req` at cycle 0, `done` at cycle 3.
- The next grant can be sampled at the same edge that ends `done`. Back-to-back transactions are separated by one IDLE cycle.
- `m_data_ok` beats may be non-consecutive. Gaps hold `rvalid=0`.

## Test plan
- **Single dcache read**: `dc_req`, `addr=0x1000`, with `addr_ok` and `data_ok` (`rdata=0xDEADBEEF`) each answered one cycle after the previous event → `dc_ack` cycle 1; `m_len=0`; `dc_rvalid`+`dc_done` cycle 3 with `dc_rdata=0xDEADBEEF`.
- **Icache burst**: `LINE_WORDS=8`, `addr=0x2000`, `data_ok` with one gap cycle after beat 3 → 8 `ic_rvalid` pulses in order, one-cycle hole; `ic_done` only with beat 8.
- **Simultaneous requests**: `ic_req` and `dc_req` in the same IDLE cycle → dcache granted first; icache granted in the IDLE cycle after `dc_done`.
- **Starvation**: `ic_req` held while `dc_req` re-raises immediately after every done → grants 1-4 go to dcache, grant 5 goes to icache, and the counter clears.
- **Dcache write**: `dc_wr=1`, `wstrb=4'b0011`, `addr_ok` delayed 5 cycles → `m_req` held 6 cycles with fields stable; `dc_done` with `dc_rvalid=0`.
- **Reset during beat 4 of an icache burst**: `resetn=0` → all outputs 0 immediately. After release, a fresh `dc_req` gets its `ack` one cycle later.
